// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller and its datapath.
// Carries the decoded IR fields, ALU flags, the memory handshake and every
// mux select / write enable the controller produces.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero;
  logic       neg;
  logic       mem_ready;

  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal;

  // Controller side: consumes IR fields and flags, drives the controls.
  modport master (
    input  opcode, func3, zero, neg, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );

  // Datapath side: the mirror image.
  modport slave (
    output opcode, func3, zero, neg, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I-subset datapath.
// Only the state is registered; every control output is decoded from the
// state, with IRWrite/PCWrite additionally qualified by mem_ready or the
// branch condition. JAL and the second step of JALR drive identical controls
// and share one state (JUMP), which keeps all live encodings in 0..13.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    LUI      = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JALR     = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t state_q, state_d;
  logic   branchTaken;

  // State register; reset wins over any pending transition, even mid-wait.
  always_ff @(posedge clk) begin
    if (rst) state_q <= state_t'(RESET_STATE);
    else     state_q <= state_d;
  end

  // Branch condition from func3; unsupported compares behave as a nop.
  always_comb begin
    branchTaken = 1'b0;
    case (ctrl.func3)
      3'b000:  branchTaken = ctrl.zero;
      3'b001:  branchTaken = ~ctrl.zero;
      3'b100:  branchTaken = ctrl.neg;
      3'b101:  branchTaken = ~ctrl.neg;
      default: branchTaken = 1'b0;
    endcase
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    ctrl.ImmSrc = 3'b000;
    case (ctrl.opcode)
      OP_SW:   ctrl.ImmSrc = 3'b001;
      OP_BR:   ctrl.ImmSrc = 3'b010;
      OP_JAL:  ctrl.ImmSrc = 3'b011;
      OP_LUI:  ctrl.ImmSrc = 3'b100;
      default: ctrl.ImmSrc = 3'b000;
    endcase
  end

  // Next-state and control decode; reset masks every side-effecting enable.
  always_comb begin
    state_d        = state_q;
    ctrl.mem_req   = 1'b0;
    ctrl.MemWrite  = 1'b0;
    ctrl.AdrSrc    = 1'b0;
    ctrl.IRWrite   = 1'b0;
    ctrl.PCWrite   = 1'b0;
    ctrl.RegWrite  = 1'b0;
    ctrl.ResultSrc = 2'b00;
    ctrl.ALUSrcA   = 2'b00;
    ctrl.ALUSrcB   = 2'b00;
    ctrl.ALUOp     = 2'b00;
    ctrl.illegal   = 1'b0;

    case (state_q)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ALUSrcB   = 2'b10;
        ctrl.ResultSrc = 2'b10;
        ctrl.IRWrite   = ctrl.mem_ready;
        ctrl.PCWrite   = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b01;
        case (ctrl.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JUMP;
          OP_JALR:      state_d = JALR;
          OP_LUI:       state_d = LUI;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
        state_d      = (ctrl.opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.AdrSrc  = 1'b1;
        if (ctrl.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl.ResultSrc = 2'b01;
        ctrl.RegWrite  = 1'b1;
        state_d        = FETCH;
      end
      MEMWRITE: begin
        ctrl.mem_req  = 1'b1;
        ctrl.AdrSrc   = 1'b1;
        ctrl.MemWrite = 1'b1;
        if (ctrl.mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b00;
        ctrl.ALUOp   = 2'b10;
        state_d      = ALUWB;
      end
      EXEC_I: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
        ctrl.ALUOp   = 2'b11;
        state_d      = ALUWB;
      end
      LUI: begin
        ctrl.ALUSrcA = 2'b11;
        ctrl.ALUSrcB = 2'b01;
        state_d      = ALUWB;
      end
      ALUWB: begin
        ctrl.RegWrite = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b00;
        ctrl.ALUOp   = 2'b01;
        ctrl.PCWrite = branchTaken;
        state_d      = FETCH;
      end
      JUMP: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b10;
        ctrl.PCWrite = 1'b1;
        state_d      = ALUWB;
      end
      JALR: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
        state_d      = JUMP;
      end
      ILLEGAL: begin
        ctrl.illegal = 1'b1;
        state_d      = ILLEGAL;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      ctrl.mem_req  = 1'b0;
      ctrl.MemWrite = 1'b0;
      ctrl.IRWrite  = 1'b0;
      ctrl.PCWrite  = 1'b0;
      ctrl.RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. A reference model expands each
// instruction into the list of control words the datapath should see, one
// per cycle, from the instruction-level rules; the bench replays the inputs
// and compares the full control word every cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [2:0] immSrc;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      exp;
    logic       ready;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       n;
  } step_t;

  logic clk;
  logic rst;
  multicycle_controller_if bus ();

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int checks;
  int failures;
  step_t expQ[$];
  logic [6:0] curOp;
  logic [2:0] curF3;
  logic curZ;
  logic curN;

  always #5 clk = ~clk;

  function automatic logic [2:0] immFor(input logic [6:0] op);
    if (op == OP_SW)  return 3'b001;
    if (op == OP_BR)  return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic takenFor(input logic [2:0] f3, input logic z, input logic n);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return n;
    if (f3 == 3'b101) return !n;
    return 1'b0;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t idle();
    ctrl_t w;
    w = '0;
    w.immSrc = immFor(curOp);
    return w;
  endfunction

  function automatic ctrl_t observe();
    ctrl_t w;
    w.memReq    = bus.mem_req;
    w.memWrite  = bus.MemWrite;
    w.adrSrc    = bus.AdrSrc;
    w.irWrite   = bus.IRWrite;
    w.pcWrite   = bus.PCWrite;
    w.regWrite  = bus.RegWrite;
    w.resultSrc = bus.ResultSrc;
    w.aluSrcA   = bus.ALUSrcA;
    w.aluSrcB   = bus.ALUSrcB;
    w.aluOp     = bus.ALUOp;
    w.immSrc    = bus.ImmSrc;
    w.illegal   = bus.illegal;
    return w;
  endfunction

  task automatic pushStep(input ctrl_t w, input logic ready);
    step_t s;
    s.exp = w; s.ready = ready; s.op = curOp; s.f3 = curF3; s.z = curZ; s.n = curN;
    expQ.push_back(s);
  endtask

  function automatic ctrl_t fetchWord(input logic done);
    ctrl_t w;
    w = idle();
    w.memReq = 1'b1; w.resultSrc = 2'b10; w.aluSrcB = 2'b10;
    w.irWrite = done; w.pcWrite = done;
    return w;
  endfunction

  function automatic ctrl_t aluWord(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    ctrl_t w;
    w = idle();
    w.aluSrcA = a; w.aluSrcB = b; w.aluOp = op;
    return w;
  endfunction

  // Expand one instruction into its expected per-cycle control words.
  task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input logic n, input int fw, input int mw);
    ctrl_t w;
    curOp = op; curF3 = f3; curZ = z; curN = n;
    for (int i = 0; i <= fw; i++) pushStep(fetchWord(i == fw), i == fw);
    pushStep(aluWord(2'b01, 2'b01, 2'b00), rnd());
    if (op == OP_LW || op == OP_SW) begin
      pushStep(aluWord(2'b10, 2'b01, 2'b00), rnd());
      for (int i = 0; i <= mw; i++) begin
        w = idle(); w.memReq = 1'b1; w.adrSrc = 1'b1; w.memWrite = (op == OP_SW);
        pushStep(w, i == mw);
      end
      if (op == OP_LW) begin
        w = idle(); w.resultSrc = 2'b01; w.regWrite = 1'b1; pushStep(w, rnd());
      end
    end else if (op == OP_BR) begin
      w = aluWord(2'b10, 2'b00, 2'b01); w.pcWrite = takenFor(f3, z, n); pushStep(w, rnd());
    end else if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_JAL || op == OP_JALR) begin
      if (op == OP_R)    pushStep(aluWord(2'b10, 2'b00, 2'b10), rnd());
      if (op == OP_I)    pushStep(aluWord(2'b10, 2'b01, 2'b11), rnd());
      if (op == OP_LUI)  pushStep(aluWord(2'b11, 2'b01, 2'b00), rnd());
      if (op == OP_JALR) pushStep(aluWord(2'b10, 2'b01, 2'b00), rnd());
      if (op == OP_JAL || op == OP_JALR) begin
        w = aluWord(2'b01, 2'b10, 2'b00); w.pcWrite = 1'b1; pushStep(w, rnd());
      end
      w = idle(); w.regWrite = 1'b1; pushStep(w, rnd());
    end else begin
      for (int i = 0; i < 10; i++) begin
        w = idle(); w.illegal = 1'b1; pushStep(w, rnd());
      end
    end
  endtask

  task automatic applyStimulus(input step_t s, input logic r);
    @(negedge clk);
    bus.opcode = s.op; bus.func3 = s.f3; bus.zero = s.z; bus.neg = s.n;
    bus.mem_ready = s.ready; rst = r;
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    ctrl_t got;
    curOp = OP_R; curF3 = 3'b000; curZ = 1'b0; curN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s.exp = fetchWord(1'b0); s.exp.memReq = 1'b0;
      s.ready = 1'b1; s.op = curOp; s.f3 = curF3; s.z = 1'b0; s.n = 1'b0;
      applyStimulus(s, 1'b1);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL reset cycle=%0d got=%h expected=%h", i, got, s.exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    buildInstr(OP_I, 3'b000, 1'b0, 1'b0, 1, 0);
    buildInstr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL alu_ops cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_load_wait();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL load_wait cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_BR, 3'b000, 1'b1, 1'b0, 0, 0);
    buildInstr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    buildInstr(OP_BR, 3'b101, 1'b0, 1'b1, 0, 0);
    buildInstr(OP_BR, 3'b010, 1'b1, 1'b1, 0, 0);
    buildInstr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    buildInstr(OP_BR, 3'b100, 1'b0, 1'b1, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL branch cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_jumps();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0);
    buildInstr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL jumps cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_store_reset();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 6);
    while (expQ.size() > 5) expQ.delete(expQ.size() - 1);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL store_reset cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
    s.exp = idle(); s.exp.adrSrc = 1'b1; s.ready = 1'b0;
    applyStimulus(s, 1'b1);
    got = observe();
    checks++;
    if (got !== s.exp) begin
      failures++;
      $display("[TB] FAIL store_reset_rst got=%h expected=%h", got, s.exp);
    end
    s.exp = fetchWord(1'b0);
    applyStimulus(s, 1'b0);
    got = observe();
    checks++;
    if (got !== s.exp) begin
      failures++;
      $display("[TB] FAIL store_reset_fetch got=%h expected=%h", got, s.exp);
    end
  endtask

  task automatic test_illegal();
    step_t s;
    ctrl_t got;
    int cyc = 0;
    buildInstr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL illegal cycle=%0d got=%h expected=%h", cyc, got, s.exp);
      end
      cyc++;
    end
    s.exp = idle(); s.exp.illegal = 1'b1; s.ready = 1'b1;
    applyStimulus(s, 1'b1);
    got = observe();
    checks++;
    if (got !== s.exp) begin
      failures++;
      $display("[TB] FAIL illegal_rst got=%h expected=%h", got, s.exp);
    end
    s.exp = fetchWord(1'b0); s.ready = 1'b0;
    applyStimulus(s, 1'b0);
    got = observe();
    checks++;
    if (got !== s.exp) begin
      failures++;
      $display("[TB] FAIL illegal_cleared got=%h expected=%h", got, s.exp);
    end
  endtask

  task automatic test_random();
    step_t s;
    ctrl_t got;
    logic [6:0] ops [8];
    int cyc = 0;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    for (int k = 0; k < 40; k++) begin
      buildInstr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), rnd(), rnd(),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      applyStimulus(s, 1'b0);
      got = observe();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d op=%b f3=%b got=%h expected=%h",
                 cyc, s.op, s.f3, got, s.exp);
      end
      cyc++;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.opcode = OP_R; bus.func3 = 3'b000; bus.zero = 1'b0; bus.neg = 1'b0;
    bus.mem_ready = 1'b0;
    checks = 0;
    failures = 0;
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_jumps();
    test_store_reset();
    test_random();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I-subset datapath: one shared ALU, one unified instruction/data memory, and the IR, OldPC, ALUOut and Data registers.
- Sequences fetch, decode, execute, memory and writeback steps and drives every datapath mux select and write enable.
- Issues the 2-bit ALUOp consumed by the separate ALU decoder: 00 add, 01 branch subtract, 10 R-type, 11 I-type.
- Handles a variable-latency memory through a req/ready handshake.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- func3  in  3  IR[14:12].
- zero  in  1  ALU result == 0.
- neg  in  1  ALU result sign bit, for signed compare.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access active.
- MemWrite  out  1  store enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  PC enable.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ALUOp  out  2  to the ALU decoder.
- ImmSrc  out  3  immediate format: I 000, S 001, B 010, J 011, U 100.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Register only the 4-bit state. All outputs are combinational from state; PCWrite and IRWrite are also qualified by inputs.
- Any output not listed for a state is 0.
- ImmSrc decodes from opcode in every state: sw gives S, branch gives B, jal gives J, lui gives U, everything else gives I.
- Reset:
  - rst sampled high sets state to FETCH on that edge, including mid-instruction or mid-wait.
  - While rst is high, MemWrite, PCWrite, IRWrite and RegWrite are forced to 0 and mem_req is 0.
  - rst clears illegal.
- FETCH:
  - mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Hold in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00, which places the branch/jal target in ALUOut. Next state by opcode:
  - 0000011 or 0100011: MEMADR.
  - 0110011: EXEC_R.
  - 0010011: EXEC_I.
  - 1100011: BRANCH.
  - 1101111: JAL.
  - 1100111: JALR.
  - 0110111: LUI.
  - Any other opcode: ILLEGAL.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Go to MEMREAD if opcode is lw, otherwise MEMWRITE.
- MEMREAD:
  - mem_req = 1, AdrSrc = 1.
  - Hold while mem_ready = 0; the Data register captures each cycle.
  - Go to MEMWB when mem_ready = 1.
- MEMWB: ResultSrc = 01, RegWrite = 1. Go to FETCH.
- MEMWRITE:
  - mem_req = 1, AdrSrc = 1, MemWrite = 1, held constant through any wait.
  - Go to FETCH when mem_ready = 1.
- EXEC_R: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Go to ALUWB.
- EXEC_I: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 11. Go to ALUWB.
- LUI: ALUSrcA = 11, ALUSrcB = 01, ALUOp = 00. Go to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Go to FETCH.
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = taken, where taken is: func3 000 zero; 001 ~zero; 100 neg; 101 ~neg; any other func3 0 (treated as a nop).
  - Go to FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1. The PC gets the target held in ALUOut and the ALU computes OldPC+4. Go to ALUWB.
- JALR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00, which places rs1+imm in ALUOut. Go to JALR_PC.
- JALR_PC: same outputs as JAL. Go to ALUWB.
- ILLEGAL: all enables 0, illegal = 1. Stays in ILLEGAL until rst.
- Latencies in cycles with zero memory wait: R/I/lui 4, lw 5, sw 4, branch 3, jal 4, jalr 5. Each wait cycle adds 1.
- Encodings 4'd14–4'd15 are unused; if reached, go to FETCH on the next edge.

Test Plan:
- add (0110011, func3 000), mem_ready = 1: state sequence FETCH, DECODE, EXEC_R, ALUWB; ALUOp = 10 in EXEC_R; RegWrite = 1 only in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD: mem_req and AdrSrc = 1 held for those 4 cycles; MEMWB one cycle after ready; ResultSrc = 01; total 8 cycles.
- beq: zero = 1 gives PCWrite = 1 in BRANCH with ALUOp = 01; zero = 0 gives PCWrite = 0. bge with neg = 1 gives PCWrite = 0. func3 010 gives PCWrite = 0.
- jalr: PCWrite = 1 only in JALR_PC; ALUWB in cycle 5 with ResultSrc = 00.
- sw with rst asserted during a MEMWRITE wait: MemWrite = 0 in the reset cycle; state is FETCH the next cycle.
- opcode 1111111: illegal = 1 from the cycle after DECODE, no enables active; it persists 10 cycles, and rst clears it.
